// File: rtl/picorv32_pcpi_muldiv.sv
// PCPI multiply/divide coprocessor: carry-save multiplier plus optional restoring divider.
// Define PCPI_MULDIV_DIV_EN to build the DIV/DIVU/REM/REMU group and its datapath.
module picorv32_pcpi_muldiv #(
    parameter int STEPS_AT_ONCE = 1,
    parameter int CARRY_CHAIN   = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // CARRY_CHAIN of 0 selects the pure carry-save adder; CC_W keeps slice widths legal either way.
    localparam int CC_W = (CARRY_CHAIN == 0) ? 64 : CARRY_CHAIN;

    state_t       state_r;
    state_t       state_next_s;
    logic [1:0]   f3_r;
    logic [6:0]   cnt_r;
    logic [6:0]   mul_last_s;
    logic         md_match_s;
    logic         mul_match_s;
    logic         div_match_s;
    logic         unused_insn_s;

    logic [63:0]  mul_rs1_r;
    logic [63:0]  mul_rs2_r;
    logic [63:0]  mul_rd_r;
    logic [63:0]  mul_rdx_r;
    logic [63:0]  nrs1_s;
    logic [63:0]  nrs2_s;
    logic [63:0]  nrd_s;
    logic [63:0]  nrdx_s;
    logic [63:0]  addend_s;
    logic [63:0]  sum_s;
    logic [63:0]  carry_s;
    logic [CC_W:0] seg_s;
    logic [63:0]  mul_full_s;
    logic [31:0]  mul_result_s;
    logic [31:0]  result_s;

    assign unused_insn_s = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

    // Instruction decode for the M extension word.
    always_comb begin
        md_match_s  = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001);
        mul_match_s = md_match_s && !pcpi_insn[14];
`ifdef PCPI_MULDIV_DIV_EN
        div_match_s = md_match_s && pcpi_insn[14];
`else
        div_match_s = 1'b0;
`endif
    end

    // Iteration count of the running multiply: plain MUL needs only the low word.
    always_comb begin
        if (f3_r == 2'b00) begin
            mul_last_s = 7'(32 / STEPS_AT_ONCE);
        end else begin
            mul_last_s = 7'(64 / STEPS_AT_ONCE);
        end
    end

    // Next-state logic; a dropped pcpi_valid abandons the operation.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (pcpi_valid && mul_match_s) begin
                    state_next_s = MUL;
                end else if (pcpi_valid && div_match_s) begin
                    state_next_s = DIV;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MUL: begin
                if (!pcpi_valid) begin
                    state_next_s = IDLE;
                end else if (cnt_r == mul_last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = MUL;
                end
            end
            DIV: begin
                if (!pcpi_valid) begin
                    state_next_s = IDLE;
                end else if (cnt_r == 7'd32) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DIV;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Iteration counter, cleared whenever no iteration is taking place.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_r <= 7'd0;
        end else if ((state_next_s == state_r) && ((state_r == MUL) || (state_r == DIV))) begin
            cnt_r <= cnt_r + 7'd1;
        end else begin
            cnt_r <= 7'd0;
        end
    end

    // Operation select latched at accept.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            f3_r <= 2'b00;
        end else if ((state_r == IDLE) && (state_next_s != IDLE)) begin
            f3_r <= pcpi_insn[13:12];
        end else begin
            f3_r <= f3_r;
        end
    end

    // STEPS_AT_ONCE shift-and-add steps kept in carry-save form (rd + rdx = partial product).
    always_comb begin
        nrs1_s   = mul_rs1_r;
        nrs2_s   = mul_rs2_r;
        nrd_s    = mul_rd_r;
        nrdx_s   = mul_rdx_r;
        addend_s = 64'd0;
        sum_s    = 64'd0;
        carry_s  = 64'd0;
        seg_s    = '0;
        for (int i = 0; i < STEPS_AT_ONCE; i++) begin
            addend_s = nrs1_s[0] ? nrs2_s : 64'd0;
            carry_s  = 64'd0;
            if (CARRY_CHAIN == 0) begin
                sum_s   = nrd_s ^ nrdx_s ^ addend_s;
                carry_s = (nrd_s & nrdx_s) | (nrd_s & addend_s) | (nrdx_s & addend_s);
            end else begin
                // rdx holds at most one set bit per segment, so a segment sum fits CC_W+1 bits.
                for (int j = 0; j < 64; j += CC_W) begin
                    seg_s = {1'b0, nrd_s[j +: CC_W]} + {1'b0, nrdx_s[j +: CC_W]}
                          + {1'b0, addend_s[j +: CC_W]};
                    sum_s[j +: CC_W]     = seg_s[CC_W-1:0];
                    carry_s[j + CC_W - 1] = seg_s[CC_W];
                end
            end
            nrd_s  = sum_s;
            nrdx_s = carry_s << 1;
            nrs1_s = nrs1_s >> 1;
            nrs2_s = nrs2_s << 1;
        end
    end

    // Multiplier operand and accumulator registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mul_rs1_r <= 64'd0;
            mul_rs2_r <= 64'd0;
            mul_rd_r  <= 64'd0;
            mul_rdx_r <= 64'd0;
        end else if ((state_r == IDLE) && (state_next_s == MUL)) begin
            // MULHU treats both operands unsigned, MULHSU only rs2.
            mul_rs1_r <= (pcpi_insn[13:12] == 2'b11) ? {32'd0, pcpi_rs1}
                                                     : {{32{pcpi_rs1[31]}}, pcpi_rs1};
            mul_rs2_r <= pcpi_insn[13] ? {32'd0, pcpi_rs2} : {{32{pcpi_rs2[31]}}, pcpi_rs2};
            mul_rd_r  <= 64'd0;
            mul_rdx_r <= 64'd0;
        end else if ((state_r == MUL) && (state_next_s == MUL)) begin
            mul_rs1_r <= nrs1_s;
            mul_rs2_r <= nrs2_s;
            mul_rd_r  <= nrd_s;
            mul_rdx_r <= nrdx_s;
        end else begin
            mul_rs1_r <= mul_rs1_r;
            mul_rs2_r <= mul_rs2_r;
            mul_rd_r  <= mul_rd_r;
            mul_rdx_r <= mul_rdx_r;
        end
    end

    // Resolve the carry-save pair and pick the requested product half.
    always_comb begin
        mul_full_s = mul_rd_r + mul_rdx_r;
        if (f3_r == 2'b00) begin
            mul_result_s = mul_full_s[31:0];
        end else begin
            mul_result_s = mul_full_s[63:32];
        end
    end

`ifdef PCPI_MULDIV_DIV_EN
    logic [31:0] div_quo_r;
    logic [31:0] div_rem_r;
    logic [31:0] div_dvs_r;
    logic        div_neg_q_r;
    logic        div_neg_r_r;
    logic        div_signed_s;
    logic [31:0] div_abs_a_s;
    logic [31:0] div_abs_b_s;
    logic [32:0] div_shift_s;
    logic [32:0] div_diff_s;
    logic [31:0] div_result_s;

    // Operand magnitudes and one restoring step.
    always_comb begin
        div_signed_s = !pcpi_insn[12];
        div_abs_a_s  = (div_signed_s && pcpi_rs1[31]) ? (32'd0 - pcpi_rs1) : pcpi_rs1;
        div_abs_b_s  = (div_signed_s && pcpi_rs2[31]) ? (32'd0 - pcpi_rs2) : pcpi_rs2;
        div_shift_s  = {div_rem_r, div_quo_r[31]};
        div_diff_s   = div_shift_s - {1'b0, div_dvs_r};
    end

    // Divider registers: the dividend shifts out of quo while quotient bits shift in.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_quo_r   <= 32'd0;
            div_rem_r   <= 32'd0;
            div_dvs_r   <= 32'd0;
            div_neg_q_r <= 1'b0;
            div_neg_r_r <= 1'b0;
        end else if ((state_r == IDLE) && (state_next_s == DIV)) begin
            div_quo_r   <= div_abs_a_s;
            div_rem_r   <= 32'd0;
            div_dvs_r   <= div_abs_b_s;
            // A zero divisor must leave the all-ones quotient un-negated.
            div_neg_q_r <= div_signed_s && (pcpi_rs1[31] ^ pcpi_rs2[31]) && (pcpi_rs2 != 32'd0);
            div_neg_r_r <= div_signed_s && pcpi_rs1[31];
        end else if ((state_r == DIV) && (state_next_s == DIV)) begin
            if (!div_diff_s[32]) begin
                div_rem_r <= div_diff_s[31:0];
                div_quo_r <= {div_quo_r[30:0], 1'b1};
            end else begin
                div_rem_r <= div_shift_s[31:0];
                div_quo_r <= {div_quo_r[30:0], 1'b0};
            end
        end else begin
            div_quo_r   <= div_quo_r;
            div_rem_r   <= div_rem_r;
            div_dvs_r   <= div_dvs_r;
            div_neg_q_r <= div_neg_q_r;
            div_neg_r_r <= div_neg_r_r;
        end
    end

    // Sign correction of quotient or remainder.
    always_comb begin
        if (f3_r[1]) begin
            div_result_s = div_neg_r_r ? (32'd0 - div_rem_r) : div_rem_r;
        end else begin
            div_result_s = div_neg_q_r ? (32'd0 - div_quo_r) : div_quo_r;
        end
    end

    // Result source follows the unit that is finishing.
    always_comb begin
        if (state_r == DIV) begin
            result_s = div_result_s;
        end else begin
            result_s = mul_result_s;
        end
    end
`else
    // Result source: multiplier only.
    always_comb begin
        result_s = mul_result_s;
    end
`endif

    // Registered PCPI outputs; pcpi_rd keeps the last result outside DONE.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pcpi_wait  <= 1'b0;
            pcpi_ready <= 1'b0;
            pcpi_wr    <= 1'b0;
            pcpi_rd    <= 32'd0;
        end else begin
            pcpi_wait  <= (state_next_s == MUL) || (state_next_s == DIV);
            pcpi_ready <= (state_next_s == DONE);
            pcpi_wr    <= (state_next_s == DONE);
            if (state_next_s == DONE) begin
                pcpi_rd <= result_s;
            end else begin
                pcpi_rd <= pcpi_rd;
            end
        end
    end

endmodule

// File: tb/tb_picorv32_pcpi_muldiv.sv
// Directed self-checking bench: dut_a uses default parameters, dut_b STEPS_AT_ONCE=8 with pure carry-save.
module tb_picorv32_pcpi_muldiv;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        valid_a;
    logic        valid_b;
    logic        wr_a, ready_a, wait_a;
    logic        wr_b, ready_b, wait_b;
    logic [31:0] rd_a, rd_b;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    picorv32_pcpi_muldiv dut_a (
        .clk        (clk),
        .resetn     (resetn),
        .pcpi_valid (valid_a),
        .pcpi_insn  (insn),
        .pcpi_rs1   (rs1),
        .pcpi_rs2   (rs2),
        .pcpi_wr    (wr_a),
        .pcpi_rd    (rd_a),
        .pcpi_wait  (wait_a),
        .pcpi_ready (ready_a)
    );

    picorv32_pcpi_muldiv #(.STEPS_AT_ONCE(8), .CARRY_CHAIN(0)) dut_b (
        .clk        (clk),
        .resetn     (resetn),
        .pcpi_valid (valid_b),
        .pcpi_insn  (insn),
        .pcpi_rs1   (rs1),
        .pcpi_rs2   (rs2),
        .pcpi_wr    (wr_b),
        .pcpi_rd    (rd_b),
        .pcpi_wait  (wait_b),
        .pcpi_ready (ready_b)
    );

    function automatic logic [31:0] md_insn(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction; latency counted in edges after the accepting edge.
    task automatic run_op(input bit on_b, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_rd,
                          input int exp_lat, input string tag);
        int lat = -1;
        @(negedge clk);
        insn = md_insn(f3);
        rs1  = a;
        rs2  = b;
        if (on_b) valid_b = 1'b1; else valid_a = 1'b1;
        @(posedge clk); #1;
        check({tag, " wait"}, {31'd0, on_b ? wait_b : wait_a}, 32'd1);
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if ((on_b ? ready_b : ready_a) === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rd"}, on_b ? rd_b : rd_a, exp_rd);
        check({tag, " wr"}, {31'd0, on_b ? wr_b : wr_a}, 32'd1);
        check({tag, " wait in done"}, {31'd0, on_b ? wait_b : wait_a}, 32'd0);
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
        @(posedge clk); #1;
        check({tag, " ready pulse"}, {31'd0, on_b ? ready_b : ready_a}, 32'd0);
        check({tag, " rd held"}, on_b ? rd_b : rd_a, exp_rd);
    endtask

    // Holds a word that must not be claimed and checks wait/ready stay low.
    task automatic hold_unclaimed(input logic [31:0] word, input int cycles, input string tag);
        bit seen = 1'b0;
        @(negedge clk);
        insn    = word;
        rs1     = 32'd100;
        rs2     = 32'd7;
        valid_a = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (wait_a || ready_a || wr_a) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd0);
        @(negedge clk);
        valid_a = 1'b0;
    endtask

    // Reset asserted ten iterations into an operation; nothing may complete afterwards.
    task automatic reset_midway(input logic [2:0] f3, input string tag);
        bit seen = 1'b0;
        @(negedge clk);
        insn    = md_insn(f3);
        rs1     = 32'hFFFF_FFF9;
        rs2     = 32'd2;
        valid_a = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk); #1;
        check({tag, " outputs"}, {rd_a[28:0], wait_a, ready_a, wr_a}, 32'd0);
        @(negedge clk);
        resetn  = 1'b1;
        valid_a = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (ready_a || wr_a) seen = 1'b1;
        end
        check({tag, " no ready"}, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        bit seen;
        resetn  = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        insn    = 32'd0;
        rs1     = 32'd0;
        rs2     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset a", {rd_a[28:0], wait_a, ready_a, wr_a}, 32'd0);
        check("reset b", {rd_b[28:0], wait_b, ready_b, wr_b}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_op(1'b0, 3'b000, 32'd7, 32'd6, 32'h0000_002A, 33, "mul 7*6");
        run_op(1'b0, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 65, "mulh -1");
        run_op(1'b0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 65, "mulhu -1");
        run_op(1'b0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 65, "mulhsu -1");
        run_op(1'b0, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, "mul -1");
        run_op(1'b0, 3'b011, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 65, "mulhu fffffffe*3");
        run_op(1'b0, 3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 65, "mulh -2*3");
        run_op(1'b0, 3'b000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 33, "mul -2*3");
        run_op(1'b0, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 65, "mulh min*min");

        run_op(1'b1, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 9, "steps8 mulh -1");
        run_op(1'b1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 9, "steps8 mulhu -1");
        run_op(1'b1, 3'b000, 32'd7, 32'd6, 32'h0000_002A, 5, "steps8 mul 7*6");

        hold_unclaimed({7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 10, "add not claimed");
        hold_unclaimed({7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0010011}, 10, "opcode not claimed");

        // Abort: drop pcpi_valid ten iterations into MULH.
        @(negedge clk);
        insn    = md_insn(3'b001);
        rs1     = 32'hFFFF_FFFF;
        rs2     = 32'hFFFF_FFFF;
        valid_a = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        check("abort busy", {31'd0, wait_a}, 32'd1);
        @(negedge clk);
        valid_a = 1'b0;
        @(posedge clk); #1;
        check("abort wait", {31'd0, wait_a}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (ready_a || wr_a) seen = 1'b1;
        end
        check("abort no ready", {31'd0, seen}, 32'd0);
        run_op(1'b0, 3'b000, 32'd3, 32'd5, 32'h0000_000F, 33, "mul 3*5");

        reset_midway(3'b001, "reset mid mulh");

`ifdef PCPI_MULDIV_DIV_EN
        run_op(1'b0, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div -7/2");
        run_op(1'b0, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem -7/2");
        run_op(1'b0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, "div overflow");
        run_op(1'b0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, "rem overflow");
        run_op(1'b0, 3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF, 33, "divu by 0");
        run_op(1'b0, 3'b111, 32'd100, 32'd0, 32'h0000_0064, 33, "remu by 0");
        run_op(1'b0, 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 33, "div -7 by 0");
        run_op(1'b0, 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 33, "rem -7 by 0");
        run_op(1'b0, 3'b100, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 33, "div 20/-3");
        run_op(1'b0, 3'b110, 32'd20, 32'hFFFF_FFFD, 32'h0000_0002, 33, "rem 20/-3");
        run_op(1'b0, 3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33, "divu fffffff9/2");
        reset_midway(3'b100, "reset mid div");
`else
        hold_unclaimed(md_insn(3'b100), 100, "div not claimed");
        run_op(1'b0, 3'b000, 32'd9, 32'd11, 32'h0000_0063, 33, "mul after div");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
